// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx6 transmit-FIFO arbiter.
// Holds the state encoding, header nibble and the round-robin search function.
package uart_arb_pkg;

   localparam int unsigned IDX_W   = 3;
   localparam int unsigned MAX_REQ = 8;

   localparam logic [3:0] TAG_NIBBLE = 4'hA;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TAG   = 2'd2
   } state_t;

   // First set bit of valid_vec at or after ptr, wrapping within num_req entries.
   function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0]   ptr,
                                               input logic [MAX_REQ-1:0] valid_vec,
                                               input int unsigned        num_req);
      logic [IDX_W-1:0] win;
      logic             found;
      int unsigned      idx;
      win   = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= num_req) idx = idx - num_req;
         if ((k < num_req) && !found && valid_vec[idx[IDX_W-1:0]]) begin
            win   = idx[IDX_W-1:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority search over NUM_REQ request lines.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [IDX_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] valid,
   output logic [IDX_W-1:0]   winner,
   output logic               hit
);

   logic [MAX_REQ-1:0] valid_ext;

   always_comb begin
      valid_ext = MAX_REQ'(valid);
      winner    = next_rr(ptr, valid_ext, NUM_REQ);
      hit       = |valid;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the single uart_tx6 transmit FIFO.
// Define UART_ARB_TAG_EN to emit a {A, 0, grant_id} header byte before each packet.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned ID_W           = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_write,
   input  logic                 tx_half_full,
   input  logic                 tx_full,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 timeout_pulse
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] gidx, gidx_n;
   logic [IDX_W-1:0] rr_ptr, rr_n;
   logic [IDX_W-1:0] rr_after;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       data_n;
   logic             write_n;
   logic             tmo_n;
   logic             busy_n;
   logic [IDX_W-1:0] pick;
   logic             hit;
   logic             g_valid;
   logic             g_last;
   logic [7:0]       g_data;
   logic             room;
   logic             accept;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .ptr    (rr_ptr),
      .valid  (req_valid),
      .winner (pick),
      .hit    (hit)
   );

   // Owner's stream selection and the accept handshake.
   always_comb begin
      g_valid   = 1'b0;
      g_last    = 1'b0;
      g_data    = 8'h00;
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gidx == IDX_W'(i)) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_data  = req_data[8*i +: 8];
         end
      end
      room   = ~tx_half_full & ~tx_full;
      accept = (state == GRANT) & g_valid & room;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept & (gidx == IDX_W'(i));
      end
      rr_after = (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);
   end

   // Next-state, pointer, timeout counter and FIFO write decisions.
   always_comb begin
      state_n = state;
      gidx_n  = gidx;
      rr_n    = rr_ptr;
      cnt_n   = cnt;
      data_n  = tx_data;
      write_n = 1'b0;
      tmo_n   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (hit) begin
               gidx_n = pick;
`ifdef UART_ARB_TAG_EN
               state_n = TAG;
`else
               state_n = GRANT;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG: begin
            if (room) begin
               data_n  = {TAG_NIBBLE, 1'b0, gidx};
               write_n = 1'b1;
               state_n = GRANT;
            end
         end
`endif
         GRANT: begin
            if (accept) begin
               data_n  = g_data;
               write_n = 1'b1;
               cnt_n   = '0;
               if (g_last) begin
                  rr_n    = rr_after;
                  state_n = IDLE;
               end
            end else if (!g_valid) begin
               // Owner went quiet mid-packet; abandon the packet once the budget is spent.
               if (cnt == CNT_LAST) begin
                  tmo_n   = 1'b1;
                  rr_n    = rr_after;
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         gidx          <= '0;
         rr_ptr        <= '0;
         cnt           <= '0;
         tx_data       <= '0;
         tx_write      <= 1'b0;
         timeout_pulse <= 1'b0;
         busy          <= 1'b0;
         grant_id      <= '0;
      end else begin
         state         <= state_n;
         gidx          <= gidx_n;
         rr_ptr        <= rr_n;
         cnt           <= cnt_n;
         tx_data       <= data_n;
         tx_write      <= write_n;
         timeout_pulse <= tmo_n;
         busy          <= busy_n;
         grant_id      <= ID_W'(gidx_n);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle vector table plus FIFO-stream sequences.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ = 4;

   logic            clk;
   logic            reset;
   logic [NREQ-1:0] req_valid;
   logic [31:0]     req_data;
   logic [NREQ-1:0] req_last;
   logic [NREQ-1:0] req_ready;
   logic [7:0]      tx_data;
   logic            tx_write;
   logic            tx_half_full;
   logic            tx_full;
   logic [2:0]      grant_id;
   logic            busy;
   logic            timeout_pulse;

   uart_tx_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (16),
      .ID_W           (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_write      (tx_write),
      .tx_half_full  (tx_half_full),
      .tx_full       (tx_full),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         rep;
      logic       rst;
      logic [3:0] valid;
      logic [3:0] last;
      logic [31:0] data;
      logic       half;
      logic [3:0] e_ready;
      logic       e_write;
      logic [7:0] e_data;
      logic       e_busy;
      logic [2:0] e_gid;
      logic       e_tmo;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] mon_q[$];
   int         n_total = 0;
   int         n_pass  = 0;

   // Bytes actually delivered to the FIFO.
   always @(negedge clk) begin
      if (!reset && tx_write) mon_q.push_back(tx_data);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic add(input int rep, input logic rst, input logic [3:0] valid,
                      input logic [3:0] last, input logic [31:0] data, input logic half,
                      input logic [3:0] e_ready, input logic e_write, input logic [7:0] e_data,
                      input logic e_busy, input logic [2:0] e_gid, input logic e_tmo);
      vec_t v;
      v.rep = rep; v.rst = rst; v.valid = valid; v.last = last; v.data = data; v.half = half;
      v.e_ready = e_ready; v.e_write = e_write; v.e_data = e_data;
      v.e_busy = e_busy; v.e_gid = e_gid; v.e_tmo = e_tmo;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      tx_half_full = 1'b0; tx_full = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One single-byte packet from requester r, optionally held off by tx_full first.
   task automatic send_single(input int r, input logic [7:0] b, input int full_cycles);
      logic [7:0] exp_q[$];
      logic [7:0] got;
      bit         acc;
      int         bad;
      do_reset();
      mon_q.delete();
`ifdef UART_ARB_TAG_EN
      exp_q.push_back({4'hA, 1'b0, 3'(r)});
`endif
      exp_q.push_back(b);
      req_valid[r] = 1'b1;
      req_last[r]  = 1'b1;
      req_data[8*r +: 8] = b;
      tx_full = (full_cycles > 0);
      bad = 0;
      for (int k = 0; k < full_cycles; k++) begin
         #1;
         if (req_ready != '0 || tx_write) bad++;
         @(negedge clk);
      end
      if (full_cycles > 0) begin
         chk($sformatf("full_block_r%0d", r), bad, 0);
         chk($sformatf("full_busy_r%0d", r), busy, 1);
         chk($sformatf("full_gid_r%0d", r), grant_id, r);
      end
      tx_full = 1'b0;
      acc = 1'b0;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (req_ready[r]) acc = 1'b1;
         if (mon_q.size() >= exp_q.size()) break;
         @(negedge clk);
         if (acc) begin
            req_valid = '0;
            req_last  = '0;
         end
      end
      chk($sformatf("stream_len_r%0d", r), mon_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
         chk($sformatf("stream_r%0d_byte%0d", r, i), got, exp_q[i]);
      end
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      #1;
      chk($sformatf("idle_after_r%0d", r), busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      tx_half_full = 1'b0; tx_full = 1'b0;

`ifndef UART_ARB_TAG_EN
      // rep rst valid last data half | ready write data busy gid tmo
      add(1, 1, 4'h0, 4'h0, 32'h0, 0,          4'h0, 0, 8'h00, 0, 0, 0);
      // single requester 0x48,0x49
      add(1, 0, 4'h1, 4'h0, 32'h48, 0,         4'h0, 0, 8'h00, 0, 0, 0);
      add(1, 0, 4'h1, 4'h0, 32'h48, 0,         4'h1, 0, 8'h00, 1, 0, 0);
      add(1, 0, 4'h1, 4'h1, 32'h49, 0,         4'h1, 1, 8'h48, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 32'h00, 0,         4'h0, 1, 8'h49, 0, 0, 0);
      // back-pressure: 50 cycles of half_full mid-packet
      add(1, 0, 4'h1, 4'h0, 32'h10, 0,         4'h0, 0, 8'h49, 0, 0, 0);
      add(1, 0, 4'h1, 4'h0, 32'h10, 0,         4'h1, 0, 8'h49, 1, 0, 0);
      add(1, 0, 4'h1, 4'h0, 32'h11, 1,         4'h0, 1, 8'h10, 1, 0, 0);
      add(49, 0, 4'h1, 4'h0, 32'h11, 1,        4'h0, 0, 8'h10, 1, 0, 0);
      add(1, 0, 4'h1, 4'h1, 32'h11, 0,         4'h1, 0, 8'h10, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 32'h00, 0,         4'h0, 1, 8'h11, 0, 0, 0);
      // contention req0 {01,02,03} vs req2 {A1,A2,A3}, req0 re-requests
      add(1, 1, 4'h0, 4'h0, 32'h0, 0,          4'h0, 0, 8'h00, 0, 0, 0);
      add(1, 0, 4'h5, 4'h0, 32'h00A1_0001, 0,  4'h0, 0, 8'h00, 0, 0, 0);
      add(1, 0, 4'h5, 4'h0, 32'h00A1_0001, 0,  4'h1, 0, 8'h00, 1, 0, 0);
      add(1, 0, 4'h5, 4'h0, 32'h00A1_0002, 0,  4'h1, 1, 8'h01, 1, 0, 0);
      add(1, 0, 4'h5, 4'h1, 32'h00A1_0003, 0,  4'h1, 1, 8'h02, 1, 0, 0);
      add(1, 0, 4'h5, 4'h1, 32'h00A1_0004, 0,  4'h0, 1, 8'h03, 0, 0, 0);
      add(1, 0, 4'h5, 4'h1, 32'h00A1_0004, 0,  4'h4, 0, 8'h03, 1, 2, 0);
      add(1, 0, 4'h5, 4'h1, 32'h00A2_0004, 0,  4'h4, 1, 8'hA1, 1, 2, 0);
      add(1, 0, 4'h5, 4'h5, 32'h00A3_0004, 0,  4'h4, 1, 8'hA2, 1, 2, 0);
      add(1, 0, 4'h1, 4'h1, 32'h0000_0004, 0,  4'h0, 1, 8'hA3, 0, 2, 0);
      add(1, 0, 4'h1, 4'h1, 32'h0000_0004, 0,  4'h1, 0, 8'hA3, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 32'h0, 0,          4'h0, 1, 8'h04, 0, 0, 0);
      // timeout: req1 stalls after one byte, req3 waiting
      add(1, 0, 4'hA, 4'h8, 32'h3300_5A00, 0,  4'h0, 0, 8'h04, 0, 0, 0);
      add(1, 0, 4'hA, 4'h8, 32'h3300_5A00, 0,  4'h2, 0, 8'h04, 1, 1, 0);
      add(1, 0, 4'h8, 4'h8, 32'h3300_5A00, 0,  4'h0, 1, 8'h5A, 1, 1, 0);
      add(15, 0, 4'h8, 4'h8, 32'h3300_5A00, 0, 4'h0, 0, 8'h5A, 1, 1, 0);
      add(1, 0, 4'h8, 4'h8, 32'h3300_5A00, 0,  4'h0, 0, 8'h5A, 0, 1, 1);
      add(1, 0, 4'h8, 4'h8, 32'h3300_5A00, 0,  4'h8, 0, 8'h5A, 1, 3, 0);
      add(1, 0, 4'h0, 4'h0, 32'h0, 0,          4'h0, 1, 8'h33, 0, 3, 0);
      // reset during the second byte of a packet
      add(1, 0, 4'h1, 4'h0, 32'hC0, 0,         4'h0, 0, 8'h33, 0, 3, 0);
      add(1, 0, 4'h1, 4'h0, 32'hC0, 0,         4'h1, 0, 8'h33, 1, 0, 0);
      add(1, 0, 4'h1, 4'h0, 32'hC1, 0,         4'h1, 1, 8'hC0, 1, 0, 0);
      add(1, 1, 4'h1, 4'h0, 32'hC2, 0,         4'h0, 0, 8'h00, 0, 0, 0);
      add(1, 0, 4'h3, 4'h0, 32'hD0C0, 0,       4'h0, 0, 8'h00, 0, 0, 0);
      add(1, 0, 4'h3, 4'h0, 32'hD0C0, 0,       4'h1, 0, 8'h00, 1, 0, 0);

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].rep; k++) begin
            @(negedge clk);
            reset        = tbl[i].rst;
            req_valid    = tbl[i].valid;
            req_last     = tbl[i].last;
            req_data     = tbl[i].data;
            tx_half_full = tbl[i].half;
            tx_full      = 1'b0;
            #1;
            chk($sformatf("row%0d.%0d ready", i, k), req_ready, tbl[i].e_ready);
            chk($sformatf("row%0d.%0d write", i, k), tx_write, tbl[i].e_write);
            chk($sformatf("row%0d.%0d data", i, k), tx_data, tbl[i].e_data);
            chk($sformatf("row%0d.%0d busy", i, k), busy, tbl[i].e_busy);
            chk($sformatf("row%0d.%0d gid", i, k), grant_id, tbl[i].e_gid);
            chk($sformatf("row%0d.%0d tmo", i, k), timeout_pulse, tbl[i].e_tmo);
         end
      end
`endif

      send_single(2, 8'h77, 6);
      send_single(3, 8'h55, 0);
      send_single(0, 8'h5C, 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx6 transmit FIFO between NUM_REQ byte-stream requesters, for example the CCProg console and the sample-dump streamer. Arbitration is round-robin at packet boundaries, so one requester's message is never interleaved with another's. The block paces writes against the FIFO fill level and releases a grant whose owner stalls mid-packet for too long. It sits between the requester streams and uart_tx6 data_in/buffer_write, inside nexys4fpga.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
TIMEOUT_CYCLES, 1024, idle cycles mid-packet before a forced grant release (must be >= 2)
ID_W, 3, width of grant_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester: a byte is offered
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  per-requester: the offered byte ends the packet
req_ready  output  NUM_REQ  per-requester: byte accepted this cycle
tx_data  output  8  to uart_tx6 data_in
tx_write  output  1  to uart_tx6 buffer_write; one-cycle pulse per byte
tx_half_full  input  1  from uart_tx6 buffer_half_full
tx_full  input  1  from uart_tx6 buffer_full
grant_id  output  ID_W  index of the current owner; valid while busy
busy  output  1  a grant is held
timeout_pulse  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset values: all outputs 0 (tx_data, tx_write, req_ready, grant_id, busy, timeout_pulse). State is IDLE, timeout counter 0, round-robin pointer 0.
- State IDLE:
  - Pick the first asserted req_valid, searching from pointer rr_ptr upward with wrap-around.
  - On a hit, next cycle: state GRANT, grant_id = winner, busy = 1.
  - IDLE consumes no data; grant costs 1 cycle.
- State GRANT, accept condition: req_ready[g] = req_valid[g] & ~tx_half_full & ~tx_full. This is combinational; every other req_ready bit is 0.
- Write timing: on accept, tx_data <= req_data[g] and tx_write <= 1 are registered, so the write reaches the FIFO 1 cycle after the handshake.
- Flow control: throttling on half_full leaves at least 7 free entries, which covers the registered latency. The block never writes while tx_full is set.
- Accept with req_last[g] = 1 (end of packet):
  - rr_ptr <= g+1, wrapping to 0 after NUM_REQ-1.
  - State returns to IDLE; busy deasserts the next cycle.
  - Back-to-back packets from different requesters therefore have a 1-cycle gap.
- Timeout counter:
  - Increments in GRANT on any cycle where req_valid[g] = 0; clears on any accept.
  - Throttle cycles (valid high, FIFO at half) do not count.
  - When the counter reaches TIMEOUT_CYCLES-1: timeout_pulse = 1 for 1 cycle, rr_ptr <= g+1, state IDLE. The partial packet is abandoned, with no flush and no marker.
- Simultaneous events: a requester may raise valid in the same cycle another releases; it is considered in the next IDLE evaluation. A single-byte packet (valid & last on its first accept) is legal.
- Reset mid-packet: outputs clear immediately and asynchronously. A tx_write pulse in flight is dropped, and the FIFO is reset separately via its buffer_reset.
- Requirement on requesters: req_data and req_last must be held stable while valid=1 and ready=0.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined: adds state TAG between IDLE and GRANT.
  - On entry to TAG, the block writes one header byte {4'hA, 1'b0, grant_id} (zero-extended to 3 bits) to the FIFO once ~tx_half_full & ~tx_full holds.
  - It then enters GRANT.
  - The grant-to-first-accept latency grows by 1 cycle plus any throttle wait.
- Undefined: no TAG state and no header bytes; the byte stream is the raw concatenation of packets.

Decomposition:
- Shared package uart_arb_pkg:
  - State encoding constants: IDLE=2'd0, GRANT=2'd1, TAG=2'd2.
  - TAG_NIBBLE=4'hA.
  - A function next_rr(ptr, valid_vec) returning the winning index.
- One natural sub-module, rr_picker: a combinational round-robin priority search over NUM_REQ. The FSM, counter and write register stay in uart_tx_arbiter.

Test Plan:
1. Single requester: req0 sends 0x48,0x49 with last on 0x49, FIFO empty. Expect tx_write pulses carrying 0x48 then 0x49 on consecutive cycles, and busy low 1 cycle after the final accept.
2. Contention: req0 and req2 both hold 3-byte packets ({01,02,03}, {A1,A2,A3}) from reset. Expect the FIFO stream 01 02 03 A1 A2 A3 with no interleave; then re-requesting req0 and req2 grants req2 first (rr_ptr=1 skips to 2).
3. Back-pressure: tie tx_half_full=1 for 50 cycles mid-packet. Expect no tx_write and no req_ready during that window, no timeout_pulse, and the stream resumes intact when half_full drops.
4. Timeout: req1 sends 1 byte without last, then drops valid with TIMEOUT_CYCLES=16. Expect timeout_pulse exactly 16 cycles after the last accept, busy=0, and a pending req3 granted next.
5. Reset mid-packet: assert reset during the 2nd byte of a 4-byte packet. Expect all outputs 0 asynchronously and grant restarting at req0 after release.
6. With UART_ARB_TAG_EN: req3 sends 0x55+last. Expect FIFO bytes 0xA3, 0x55.
